// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

    localparam int SA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder cells.
// Purely combinational; feeds the serial carry loop.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s0),
        .cout (c0)
    );

    half_adder u_ha1 (
        .a    (s0),
        .b    (cin),
        .sum  (sum),
        .cout (c1)
    );

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Result and carry-out are registered with a one-cycle done strobe.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s;
    logic             fa_co;

    full_adder_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Next-state: accept in IDLE/DONE, shift one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d = fa_co;
                s_sh_d  = s_sh_q >> 1;
                s_sh_d[WIDTH-1] = fa_s;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = s_sh_d;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight add.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected values are hand-computed constants.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_vec;
    int n_err;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the start edge; counts edges until done.
    // glitch_at >= 0 pulses a new start with other operands mid-run.
    task automatic wait_done(input int glitch_at, output int lat,
                             output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (lat == glitch_at) begin
                start = 1'b1;
                a = 8'h77;
                b = 8'h11;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        if (lat >= 40) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] va,
                         input logic [7:0] vb, input int glitch_at,
                         input logic [7:0] es, input logic ec);
        int lat;
        int nb;
        start = 1'b1;
        a = va;
        b = vb;
        tick();
        start = 1'b0;
        a = ~va;
        b = ~vb;
        wait_done(glitch_at, lat, nb);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busy"}, nb, 8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        tick();
        check({tag, "_strobe"}, done, 0);
        check({tag, "_hold"}, sum, es);
    endtask

    initial begin
        int lat;
        int nb;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_sum", sum, 8'h00);
            check("rst_cout", cout, 0);
        end

        do_op("5a3c", 8'h5A, 8'h3C, -1, 8'h96, 1'b0);
        do_op("ff01", 8'hFF, 8'h01, -1, 8'h00, 1'b1);
        do_op("ffff", 8'hFF, 8'hFF, -1, 8'hFE, 1'b1);
        do_op("ign", 8'h5A, 8'h3C, 3, 8'h96, 1'b0);

        start = 1'b1;
        a = 8'h40;
        b = 8'h40;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum", sum, 8'h00);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_done", done, 0);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) nb++;
        end
        check("mid_rst_nodone", nb, 0);
        do_op("fresh", 8'h12, 8'h34, -1, 8'h46, 1'b0);

        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        tick();
        a = 8'h10;
        b = 8'h20;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_lat1", lat, 8);
        check("b2b_sum1", sum, 8'h03);
        check("b2b_cout1", cout, 0);
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_gap", lat, 9);
        check("b2b_sum2", sum, 8'h30);
        check("b2b_cout2", cout, 0);
        tick();

        start1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        check("w1_done_early", done1, 0);
        tick();
        check("w1_done", done1, 1);
        check("w1_sum", sum1, 0);
        check("w1_cout", cout1, 1);
        tick();
        check("w1_strobe", done1, 0);
        start1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b0;
        tick();
        start1 = 1'b0;
        tick();
        check("w1b_done", done1, 1);
        check("w1b_sum", sum1, 1);
        check("w1b_cout", cout1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
